// File: rtl/fetch_cur_chroma_ctrl_pkg.sv
// fetch_cur_chroma_ctrl_pkg
//   Shared types and constants for the chroma current-LCU load sequencer:
//   FSM state encoding, plane encoding, V-plane base address and a
//   saturating 16-bit increment used by the optional cycle counter.
package fetch_cur_chroma_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ_U,
    ST_DAT_U,
    ST_REQ_V,
    ST_DAT_V,
    ST_DONE
  } state_e;

  localparam logic       PLANE_U     = 1'b0;
  localparam logic       PLANE_V     = 1'b1;
  localparam logic [5:0] V_BASE_ADDR = 6'd32;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/fetch_cur_chroma_ctrl_if.sv
// fetch_cur_chroma_ctrl_if
//   Bus bundle between the load sequencer, the external fetch engine and the
//   chroma current-pixel buffer.
//   fetch_req/plane/x/y   : burst request (sequencer -> fetch engine)
//   fetch_ack             : request accepted (fetch engine -> sequencer)
//   fetch_valid/data      : returned data beats (fetch engine -> sequencer)
//   ext_load_valid/addr/data : buffer write port (sequencer -> buffer)
//   master = sequencer side, slave = fetch engine / buffer side.
interface fetch_cur_chroma_ctrl_if #(
  parameter int PIXEL_WIDTH = 8,
  parameter int LCU_CNT_W   = 8
);
  logic                     fetch_req;
  logic                     fetch_plane;
  logic [LCU_CNT_W-1:0]     fetch_x;
  logic [LCU_CNT_W-1:0]     fetch_y;
  logic                     fetch_ack;
  logic                     fetch_valid;
  logic [32*PIXEL_WIDTH-1:0] fetch_data;
  logic                     ext_load_valid;
  logic [5:0]               ext_load_addr;
  logic [32*PIXEL_WIDTH-1:0] ext_load_data;

  modport master (
    output fetch_req, fetch_plane, fetch_x, fetch_y,
    output ext_load_valid, ext_load_addr, ext_load_data,
    input  fetch_ack, fetch_valid, fetch_data
  );

  modport slave (
    input  fetch_req, fetch_plane, fetch_x, fetch_y,
    input  ext_load_valid, ext_load_addr, ext_load_data,
    output fetch_ack, fetch_valid, fetch_data
  );
endinterface

// File: rtl/fetch_cur_chroma_ctrl_lcu_pos_cnt.sv
// fetch_lcu_pos_cnt
//   LCU raster position counter with frame wrap.
//   clk, rst            : clock, synchronous active-high reset
//   adv_i               : advance one LCU (one per start pulse)
//   total_x_i/total_y_i : last LCU index in x / y
//   x_o, y_o            : current LCU position
//   The first advance after reset lands on (0,0) instead of stepping past it.
module fetch_lcu_pos_cnt #(
  parameter int LCU_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 adv_i,
  input  logic [LCU_CNT_W-1:0] total_x_i,
  input  logic [LCU_CNT_W-1:0] total_y_i,
  output logic [LCU_CNT_W-1:0] x_o,
  output logic [LCU_CNT_W-1:0] y_o
);
  localparam logic [LCU_CNT_W-1:0] ONE = 1;

  logic                 first_q;
  logic [LCU_CNT_W-1:0] x_q, y_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      first_q <= 1'b1;
      x_q     <= '0;
      y_q     <= '0;
    end else if (adv_i) begin
      if (first_q) begin
        first_q <= 1'b0;
        x_q     <= '0;
        y_q     <= '0;
      end else if (x_q == total_x_i) begin
        x_q <= '0;
        y_q <= (y_q == total_y_i) ? '0 : y_q + ONE;
      end else begin
        x_q <= x_q + ONE;
      end
    end
  end

  assign x_o = x_q;
  assign y_o = y_q;
endmodule

// File: rtl/fetch_cur_chroma_ctrl.sv
// fetch_cur_chroma_ctrl
//   Load sequencer for the triple-rotated chroma current-LCU buffer. Each
//   start pulse advances the LCU position, requests a U burst then a V burst,
//   and writes returned beats into the buffer (U -> 0..31, V -> 32..63).
//   clk, rst           : clock, synchronous active-high reset
//   sysif_start_i      : LCU start pulse
//   sysif_total_x_i/_y_i : last LCU index in x / y
//   bus (master)       : fetch request/data and buffer write port
//   ext_load_done_o    : one-cycle pulse together with the write of word 63
//   busy_o             : load in progress
//   overrun_o          : sticky, start arrived while a load was running
//   load_cycles_o      : (FETCH_CUR_CHROMA_PERF_EN only) cycles from REQ_U
//                        entry to the done pulse, saturating
module fetch_cur_chroma_ctrl
  import fetch_cur_chroma_ctrl_pkg::*;
#(
  parameter int PIXEL_WIDTH     = 8,
  parameter int WORDS_PER_PLANE = 32,
  parameter int LCU_CNT_W       = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 sysif_start_i,
  input  logic [LCU_CNT_W-1:0] sysif_total_x_i,
  input  logic [LCU_CNT_W-1:0] sysif_total_y_i,
  fetch_cur_chroma_ctrl_if.master bus,
  output logic                 ext_load_done_o,
  output logic                 busy_o,
  output logic                 overrun_o
`ifdef FETCH_CUR_CHROMA_PERF_EN
  ,
  output logic [15:0]          load_cycles_o
`endif
);
  localparam int         DATA_W    = 32 * PIXEL_WIDTH;
  localparam logic [4:0] LAST_BEAT = 5'(WORDS_PER_PLANE - 1);

  state_e              state_q;
  logic                req_q, plane_q, wr_vld_q, done_q, busy_q, ovr_q;
  logic [4:0]          beat_q;
  logic [5:0]          wr_addr_q;
  logic [DATA_W-1:0]   wr_data_q;
  logic [LCU_CNT_W-1:0] pos_x, pos_y;

  logic in_dat, in_load, beat_ok, last_v_beat;

  // Beats are only taken while a data phase is open; anything else is dropped.
  assign in_dat      = (state_q == ST_DAT_U) || (state_q == ST_DAT_V);
  assign in_load     = (state_q == ST_REQ_U) || (state_q == ST_DAT_U) ||
                       (state_q == ST_REQ_V) || (state_q == ST_DAT_V);
  assign beat_ok     = in_dat && bus.fetch_valid;
  // A start on the same edge aborts the LCU, so that beat cannot complete it.
  assign last_v_beat = (state_q == ST_DAT_V) && bus.fetch_valid &&
                       (beat_q == LAST_BEAT) && !sysif_start_i;

  fetch_lcu_pos_cnt #(.LCU_CNT_W(LCU_CNT_W)) u_pos (
    .clk       (clk),
    .rst       (rst),
    .adv_i     (sysif_start_i),
    .total_x_i (sysif_total_x_i),
    .total_y_i (sysif_total_y_i),
    .x_o       (pos_x),
    .y_o       (pos_y)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      req_q     <= 1'b0;
      plane_q   <= PLANE_U;
      wr_vld_q  <= 1'b0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
      ovr_q     <= 1'b0;
      beat_q    <= '0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      // Write path runs independently of a restart so an accepted beat
      // always lands one cycle later.
      wr_vld_q <= beat_ok;
      if (beat_ok) begin
        wr_addr_q <= (state_q == ST_DAT_V) ? (V_BASE_ADDR | {1'b0, beat_q})
                                           : {1'b0, beat_q};
        wr_data_q <= bus.fetch_data;
      end
      done_q <= 1'b0;

      if (sysif_start_i) begin
        // DONE already emitted its pulse, so a start there is a clean start.
        if (in_load) ovr_q <= 1'b1;
        state_q <= ST_REQ_U;
        req_q   <= 1'b1;
        plane_q <= PLANE_U;
        beat_q  <= '0;
        busy_q  <= 1'b1;
      end else begin
        case (state_q)
          ST_IDLE: ;
          ST_REQ_U: if (bus.fetch_ack) begin
            state_q <= ST_DAT_U;
            req_q   <= 1'b0;
          end
          ST_DAT_U: if (bus.fetch_valid) begin
            if (beat_q == LAST_BEAT) begin
              state_q <= ST_REQ_V;
              req_q   <= 1'b1;
              plane_q <= PLANE_V;
              beat_q  <= '0;
            end else begin
              beat_q <= beat_q + 5'd1;
            end
          end
          ST_REQ_V: if (bus.fetch_ack) begin
            state_q <= ST_DAT_V;
            req_q   <= 1'b0;
          end
          ST_DAT_V: if (bus.fetch_valid) begin
            if (beat_q == LAST_BEAT) begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
              beat_q  <= '0;
            end else begin
              beat_q <= beat_q + 5'd1;
            end
          end
          default: begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.fetch_req      = req_q;
  assign bus.fetch_plane    = plane_q;
  assign bus.fetch_x        = pos_x;
  assign bus.fetch_y        = pos_y;
  assign bus.ext_load_valid = wr_vld_q;
  assign bus.ext_load_addr  = wr_addr_q;
  assign bus.ext_load_data  = wr_data_q;
  assign ext_load_done_o    = done_q;
  assign busy_o             = busy_q;
  assign overrun_o          = ovr_q;

`ifdef FETCH_CUR_CHROMA_PERF_EN
  logic [15:0] cyc_q, load_cyc_q;

  // cyc_q counts completed REQ/DAT cycles; the final DAT_V cycle is added
  // when latching so the result covers REQ_U entry through the last beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      cyc_q      <= '0;
      load_cyc_q <= '0;
    end else begin
      if (sysif_start_i)  cyc_q <= '0;
      else if (in_load)   cyc_q <= sat_inc16(cyc_q);
      if (last_v_beat)    load_cyc_q <= sat_inc16(cyc_q);
    end
  end

  assign load_cycles_o = load_cyc_q;
`endif
endmodule

// File: tb/tb_fetch_cur_chroma_ctrl.sv
// tb_fetch_cur_chroma_ctrl
//   Directed sequence with random data and random request delays. Expected
//   positions come from the raster index of each start; expected writes are
//   queued from the beats the bench itself drives.
module tb_fetch_cur_chroma_ctrl;
  localparam int PW = 8;
  localparam int LW = 8;
  localparam int DW = 32 * PW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [LW-1:0] tx = '0, ty = '0;
  logic          done, busy, ovr;
`ifdef FETCH_CUR_CHROMA_PERF_EN
  logic [15:0]   load_cycles;
`endif

  fetch_cur_chroma_ctrl_if #(.PIXEL_WIDTH(PW), .LCU_CNT_W(LW)) bus ();

  fetch_cur_chroma_ctrl #(.PIXEL_WIDTH(PW), .WORDS_PER_PLANE(32), .LCU_CNT_W(LW)) dut (
    .clk             (clk),
    .rst             (rst),
    .sysif_start_i   (start),
    .sysif_total_x_i (tx),
    .sysif_total_y_i (ty),
    .bus             (bus),
    .ext_load_done_o (done),
    .busy_o          (busy),
    .overrun_o       (ovr)
`ifdef FETCH_CUR_CHROMA_PERF_EN
    ,
    .load_cycles_o   (load_cycles)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int nst   = 0;   // starts since last reset
  int act_base, nd_base;

  logic [261:0] act_q[$];
  logic [261:0] exp_q[$];
  int           ndone = 0;
  logic [6:0]   done_va = '0;

  // Monitor: every write and every done pulse, sampled mid-cycle.
  always @(negedge clk) begin
    if (bus.ext_load_valid) act_q.push_back({bus.ext_load_addr, bus.ext_load_data});
    if (done) begin
      ndone++;
      done_va = {bus.ext_load_valid, bus.ext_load_addr};
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [261:0] obs, input logic [261:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] rnd();
    logic [DW-1:0] r;
    for (int i = 0; i < DW / 32; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  // Raster model: k-th LCU since reset.
  function automatic logic [LW-1:0] ex_x(input int k);
    int m;
    m = k % (int'(tx) + 1);
    return m[LW-1:0];
  endfunction
  function automatic logic [LW-1:0] ex_y(input int k);
    int m;
    m = (k / (int'(tx) + 1)) % (int'(ty) + 1);
    return m[LW-1:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    nst++;
  endtask

  task automatic do_req(input bit pl, input int d, input bit stray);
    int w = 0;
    while (bus.fetch_req !== 1'b1 && w < 20) begin
      tick();
      w++;
    end
    chk("req_seen", bus.fetch_req, 1'b1);
    chk("req_plane", bus.fetch_plane, pl);
    chk("req_x", bus.fetch_x, ex_x(nst - 1));
    chk("req_y", bus.fetch_y, ex_y(nst - 1));
    for (int i = 0; i < d; i++) begin
      if (stray) begin
        bus.fetch_valid = 1'b1;
        bus.fetch_data  = rnd();
      end
      tick();
      bus.fetch_valid = 1'b0;
      chk("req_hold", bus.fetch_req, 1'b1);
      if (stray) chk("stray_no_write", bus.ext_load_valid, 1'b0);
    end
    bus.fetch_ack = 1'b1;
    tick();
    bus.fetch_ack = 1'b0;
    chk("req_drop", bus.fetch_req, 1'b0);
  endtask

  task automatic do_beats(input bit pl, input int n, input bit gaps);
    logic [DW-1:0] d;
    logic [5:0]    a;
    for (int i = 0; i < n; i++) begin
      d = rnd();
      a = 6'(int'(pl) * 32 + i);
      bus.fetch_valid = 1'b1;
      bus.fetch_data  = d;
      exp_q.push_back({a, d});
      tick();
      bus.fetch_valid = 1'b0;
      chk("wr_valid", bus.ext_load_valid, 1'b1);
      chk("wr_addr", bus.ext_load_addr, a);
      chk("wr_data", bus.ext_load_data, d);
      if (gaps && i != n - 1) begin
        tick();
        chk("gap_no_write", bus.ext_load_valid, 1'b0);
      end
    end
  endtask

  task automatic begin_lcu();
    exp_q.delete();
    act_base = act_q.size();
    nd_base  = ndone;
    pulse_start();
  endtask

  // Runs both planes after REQ_U has been entered; returns in the done cycle.
  task automatic run_body(input int du, input int dv, input bit gaps, input bit stray);
    do_req(1'b0, du, stray);
    do_beats(1'b0, 32, gaps);
    do_req(1'b1, dv, stray);
    do_beats(1'b1, 32, gaps);
    chk("done_pulse", done, 1'b1);
    chk("busy_in_done", busy, 1'b1);
`ifdef FETCH_CUR_CHROMA_PERF_EN
    chk("load_cycles", load_cycles, 16'(66 + du + dv + (gaps ? 62 : 0)));
`endif
  endtask

  task automatic cmp_q();
    chk("write_count", act_q.size() - act_base, exp_q.size());
    chk("done_count", ndone - nd_base, 1);
    chk("done_with_addr63", done_va, {1'b1, 6'd63});
    for (int i = 0; i < exp_q.size() && act_base + i < act_q.size(); i++)
      chk("write_seq", act_q[act_base + i], exp_q[i]);
  endtask

  task automatic end_lcu();
    tick();
    chk("done_one_cycle", done, 1'b0);
    chk("busy_fall", busy, 1'b0);
    cmp_q();
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_req"}, bus.fetch_req, 1'b0);
    chk({tag, "_plane"}, bus.fetch_plane, 1'b0);
    chk({tag, "_x"}, bus.fetch_x, '0);
    chk({tag, "_y"}, bus.fetch_y, '0);
    chk({tag, "_wvalid"}, bus.ext_load_valid, 1'b0);
    chk({tag, "_waddr"}, bus.ext_load_addr, '0);
    chk({tag, "_wdata"}, bus.ext_load_data, '0);
    chk({tag, "_done"}, done, 1'b0);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_ovr"}, ovr, 1'b0);
`ifdef FETCH_CUR_CHROMA_PERF_EN
    chk({tag, "_cycles"}, load_cycles, 16'd0);
`endif
  endtask

  initial begin
    bus.fetch_ack   = 1'b0;
    bus.fetch_valid = 1'b0;
    bus.fetch_data  = '0;

    // Reset state
    rst = 1'b1;
    tick();
    tick();
    chk_idle_outputs("reset");
    rst = 1'b0;
    tick();
    chk("idle_after_reset", busy, 1'b0);

    // Nominal LCU, ack after 3 cycles
    tx = 8'd3;
    ty = 8'd2;
    begin_lcu();
    chk("busy_rise", busy, 1'b1);
    run_body(3, 3, 1'b0, 1'b0);
    end_lcu();
    chk("no_overrun_nominal", ovr, 1'b0);

    // Start coinciding with the done cycle is a clean start
    begin_lcu();
    run_body(1, 0, 1'b0, 1'b0);
    start = 1'b1;
    tick();
    start = 1'b0;
    nst++;
    cmp_q();
    chk("done_start_no_ovr", ovr, 1'b0);
    chk("done_start_req", bus.fetch_req, 1'b1);
    exp_q.delete();
    act_base = act_q.size();
    nd_base  = ndone;
    run_body(2, 2, 1'b0, 1'b0);
    end_lcu();

    // Frame wrap 2x2, five LCUs
    rst = 1'b1;
    tick();
    rst = 1'b0;
    nst = 0;
    tx  = 8'd1;
    ty  = 8'd1;
    for (int k = 0; k < 5; k++) begin
      begin_lcu();
      run_body(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 1'b0, 1'b0);
      end_lcu();
    end
    chk("wrap_no_ovr", ovr, 1'b0);

    // Gapped beats with stray valids during both request phases
    begin_lcu();
    run_body(2, 3, 1'b1, 1'b1);
    end_lcu();

    // Overrun: restart at U beat 10
    begin_lcu();
    do_req(1'b0, 1, 1'b0);
    do_beats(1'b0, 10, 1'b0);
    pulse_start();
    chk("ovr_set", ovr, 1'b1);
    chk("ovr_busy", busy, 1'b1);
    chk("ovr_no_done", done, 1'b0);
    chk("ovr_no_write", bus.ext_load_valid, 1'b0);
    run_body(1, 1, 1'b0, 1'b0);
    end_lcu();
    chk("ovr_sticky", ovr, 1'b1);

    // Reset in the middle of DAT_V (beat 5)
    begin_lcu();
    do_req(1'b0, 0, 1'b0);
    do_beats(1'b0, 32, 1'b0);
    do_req(1'b1, 1, 1'b0);
    do_beats(1'b1, 5, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    nst = 0;
    chk_idle_outputs("midrst");
    tick();
    chk("midrst_no_done", ndone - nd_base, 0);
    begin_lcu();
    run_body(0, 0, 1'b0, 1'b0);
    end_lcu();

    // Ack delay 4 both planes, no gaps
    begin_lcu();
    run_body(4, 4, 1'b0, 1'b0);
    end_lcu();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
